sa_ws_feeder: RTL and testbench
===============================

Name: sa_ws_feeder

Overview:
- Upstream stage of the weight-stationary PE array. Buffers activation vectors arriving on a valid/ready interface, then applies diagonal skew (row j delayed j-1 cycles) before driving the array's a_vec input.
- After the last vector of a packet, injects zero vectors so partial sums drain out of the array.
- One instance per array, same clock domain.

Parameters:
SIZE, 8, activation element width in bits
ROW, 8, array rows (elements per vector)
COL, 8, array columns; used only for the drain length
DEPTH, 4, input FIFO depth in vectors; power of two, at least 2
DRAIN_CYCLES, ROW+COL-1, zero-injection cycles after the last vector

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  in_data/in_last valid
in_ready  out  1  FIFO can accept; equals not-full
in_data  in  ROW*SIZE  activation vector; row j at [SIZE*(ROW-j+1)-1 : SIZE*(ROW-j)] (row 1 in MSBs)
in_last  in  1  marks the last vector of a packet
a_vec  out  ROW*SIZE  skewed vector to the array, same row packing as in_data
a_valid  out  1  row-1 slot of a_vec carries a popped (real) vector this cycle
busy  out  1  FSM not in IDLE
drain_done  out  1  one-cycle pulse at end of DRAIN

Behaviour:
- Reset (reset=0, async): FIFO empty, count=0, all skew registers 0, a_vec=0, a_valid=0, busy=0, drain_done=0, FSM=IDLE; in_ready=1 once reset is released. Reset mid-packet discards all buffered and in-flight data.
- FIFO:
  - Push on in_valid&in_ready. Pop decided by the FSM. Push and pop in the same cycle leave count unchanged.
  - No bypass: a vector accepted at edge a is poppable at edge a+1 at the earliest.
  - Stores {in_last, in_data}; pointers wrap modulo DEPTH.
  - When full, in_ready=0. A pop in the same cycle does not raise in_ready until the next cycle.
- Skew chain:
  - Per row j, a shift register of length j, shifting every cycle.
  - Stage 1 loads row j of the injected word.
  - a_vec row j = last stage of chain j.
  - The injected word is the popped vector, or all-zero when nothing is popped.
  - Row 1 of a vector popped at edge p appears after edge p; row j appears after edge p+j-1.
  - Latency from acceptance edge to row 1 on a_vec is 2 edges when idle.
- a_valid is registered: 1 after an edge that popped a vector, else 0.
- FSM:
  - IDLE: if FIFO is non-empty, go to STREAM. No pop in this cycle.
  - STREAM: pop each cycle the FIFO is non-empty; bubble (inject zero) when empty. Popping an entry with last=1 moves to DRAIN and loads drain_cnt=DRAIN_CYCLES-1.
  - DRAIN: never pops; injects zero; decrements drain_cnt. At drain_cnt=0, pulse drain_done and go to IDLE. Vectors of the next packet stay buffered.
- Width rule: drain_cnt is clog2(DRAIN_CYCLES+1) bits. No arithmetic is performed on data.

Optional Feature:
- Macro: SA_WS_FEEDER_PERF_EN.
- Defined: adds output bubble_cnt [15:0]. It counts STREAM cycles with an empty FIFO and saturates at 16'hFFFF. It clears on reset and on each IDLE->STREAM transition.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan (all with ROW=4, COL=4, SIZE=8, DEPTH=4, DRAIN_CYCLES=7):
- Skew: push a single vector 0x01020304 with last=1 while idle. Row 1=0x01 appears 2 edges after acceptance with a_valid=1. Rows 2/3/4 appear on the following 3 edges. All other slots are 0. drain_done pulses exactly 7 cycles after the pop; busy then drops.
- Back-to-back: 4 consecutive pushes 0x11111111..0x44444444, last on the 4th. a_valid is high for 4 consecutive cycles. a_vec on the 4th valid cycle = 0x44332211.
- Backpressure: hold in_valid=1 with the FSM in DRAIN from a prior packet. in_ready drops after 4 accepts and no pops occur. After drain_done, pops resume with in_ready rising 1 cycle after the first pop.
- Bubble: push A, idle 3 cycles, push B with last=1. A zero row-1 slot with a_valid=0 appears between A and B. With SA_WS_FEEDER_PERF_EN defined, bubble_cnt=3.
- Reset mid-stream: deassert reset during STREAM with 2 entries buffered. All outputs are 0 immediately (async) and in_ready=1 after release. No stale vector appears afterward.

Source files
------------

// File: rtl/sa_ws_feeder.sv
// sa_ws_feeder: input stage of the weight-stationary PE array.
// It buffers activation vectors in a small FIFO and applies a diagonal skew,
// so that row j reaches the array j-1 cycles after row 1. After the last
// vector of a packet it injects zero vectors so that partial sums drain out.
// Optional build macro SA_WS_FEEDER_PERF_EN adds the bubble_cnt output, which
// counts STREAM cycles that found the FIFO empty.
module sa_ws_feeder #(
  parameter int unsigned SIZE         = 8,
  parameter int unsigned ROW          = 8,
  parameter int unsigned COL          = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DRAIN_CYCLES = ROW + COL - 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ROW*SIZE-1:0] in_data,
  input  logic                in_last,
  output logic [ROW*SIZE-1:0] a_vec,
  output logic                a_valid,
  output logic                busy,
  output logic                drain_done
`ifdef SA_WS_FEEDER_PERF_EN
  ,
  output logic [15:0]         bubble_cnt
`endif
);

  localparam int unsigned VW = ROW * SIZE;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  // FIFO storage: {last, data}
  logic [VW:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;
  logic [VW:0]   head;
  logic          fifo_empty;

  // FSM and drain counter
  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [DW-1:0] drain_cnt_q;
  logic [DW-1:0] drain_cnt_d;
  logic          drain_fire;

  // Word entering stage 1 of every skew chain
  logic [VW-1:0] inj;

  logic          a_valid_q;
  logic          drain_done_q;

  // in_ready is derived from the registered count. A pop in a full cycle
  // therefore raises in_ready only after the next edge.
  assign fifo_empty = (count_q == '0);
  assign in_ready   = (count_q != CW'(DEPTH));
  assign push       = in_valid & in_ready;
  assign head       = mem_q[rd_ptr_q];

  // Write the accepted vector into the FIFO. The array has no reset because
  // count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_last, in_data};
    end
  end

  // Update the FIFO pointers and occupancy. DEPTH is a power of two, so the
  // pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Next-state logic. The pop decision reads only the registered count, so a
  // vector that was just accepted cannot pass through in the same cycle.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pop         = 1'b0;
    drain_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head[VW]) begin
            state_d     = DRAIN;
            drain_cnt_d = DW'(DRAIN_CYCLES - 1);
          end
        end
      end
      DRAIN: begin
        if (drain_cnt_q == '0) begin
          drain_fire = 1'b1;
          state_d    = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register the FSM state, the drain counter and the registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      drain_cnt_q  <= '0;
      a_valid_q    <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      a_valid_q    <= pop;
      drain_done_q <= drain_fire;
    end
  end

  // A cycle without a pop (bubble, drain or idle) injects an all-zero word.
  assign inj = pop ? head[VW-1:0] : '0;

  // Skew chains: row r+1 has r+1 stages. Stage 1 sits in the low bits, and
  // the last stage (top bits) drives the matching slot of a_vec.
  for (genvar r = 0; r < ROW; r++) begin : g_row
    logic [SIZE*(r+1)-1:0] sr_q;
    logic [SIZE-1:0]       inj_row;

    assign inj_row = inj[SIZE*(ROW-r)-1 -: SIZE];

    if (r == 0) begin : g_one
      // Row 1 has a single stage and no extra delay.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sr_q <= '0;
        end else begin
          sr_q <= inj_row;
        end
      end
    end else begin : g_many
      // Shift toward the top each cycle, with a new element entering stage 1.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sr_q <= '0;
        end else begin
          sr_q <= {sr_q[SIZE*r-1:0], inj_row};
        end
      end
    end

    assign a_vec[SIZE*(ROW-r)-1 -: SIZE] = sr_q[SIZE*(r+1)-1 -: SIZE];
  end

  assign a_valid    = a_valid_q;
  assign busy       = (state_q != IDLE);
  assign drain_done = drain_done_q;

`ifdef SA_WS_FEEDER_PERF_EN
  logic [15:0] bubble_q;

  // Count starved STREAM cycles (saturating). Restart at each new packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_q <= '0;
    end else if (state_q == IDLE && state_d == STREAM) begin
      bubble_q <= '0;
    end else if (state_q == STREAM && fifo_empty && bubble_q != 16'hFFFF) begin
      bubble_q <= bubble_q + 16'd1;
    end
  end

  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_sa_ws_feeder.sv
// Self-checking bench for sa_ws_feeder (ROW=4, COL=4, SIZE=8, DEPTH=4).
// The driver pushes expected vectors into a queue. A negedge monitor
// re-assembles each skewed vector and checks it against that queue, and it
// also checks that every slot not owned by a popped vector is zero.
module tb_sa_ws_feeder;

  localparam int unsigned SIZE         = 8;
  localparam int unsigned ROW          = 4;
  localparam int unsigned COL          = 4;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned DRAIN_CYCLES = 7;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last  = 1'b0;
  logic [31:0] in_data  = '0;
  logic        in_ready;
  logic [31:0] a_vec;
  logic        a_valid;
  logic        busy;
  logic        drain_done;
`ifdef SA_WS_FEEDER_PERF_EN
  logic [15:0] bubble_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  sa_ws_feeder #(
    .SIZE(SIZE),
    .ROW(ROW),
    .COL(COL),
    .DEPTH(DEPTH),
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .a_vec(a_vec),
    .a_valid(a_valid),
    .busy(busy),
    .drain_done(drain_done)
`ifdef SA_WS_FEEDER_PERF_EN
    ,
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    exp_q.push_back(d);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (drain_done) break;
      nxt();
    end
    check("drain_done_seen", {31'b0, drain_done}, 32'h1);
    nxt();
  endtask

  // Scoreboard monitor
  initial begin : monitor
    logic [31:0] hv   [4];
    logic        hval [4];
    logic [31:0] got;
    logic [31:0] mask;
    for (int k = 0; k < 4; k++) begin
      hv[k]   = '0;
      hval[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int k = 0; k < 4; k++) begin
          hv[k]   = '0;
          hval[k] = 1'b0;
        end
      end else begin
        for (int k = 3; k > 0; k--) begin
          hv[k]   = hv[k-1];
          hval[k] = hval[k-1];
        end
        hv[0]   = a_vec;
        hval[0] = a_valid;
        // Row r+1 now holds the vector injected r cycles ago.
        mask = '0;
        for (int r = 0; r < 4; r++) begin
          if (!hval[r]) mask[31-8*r -: 8] = 8'hFF;
        end
        check("zero_slots", hv[0] & mask, 32'h0);
        if (hval[3]) begin
          got = '0;
          for (int r = 0; r < 4; r++) begin
            got[31-8*r -: 8] = hv[3-r][31-8*r -: 8];
          end
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_vec: got %h, required none", got);
          end else begin
            check("sb_vec", got, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : stim
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_vec", a_vec, 32'h0);
    check("rst_a_valid", {31'b0, a_valid}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_drain_done", {31'b0, drain_done}, 32'h0);
    reset = 1'b1;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    nxt();

    // Skew test: single vector, accepted at edge a
    drive(32'h01020304, 1'b1);
    nxt();                                         // a
    in_valid = 1'b0;
    check("skew_a0_valid", {31'b0, a_valid}, 32'h0);
    check("skew_a0_busy", {31'b0, busy}, 32'h0);
    nxt();                                         // a+1
    check("skew_a1_valid", {31'b0, a_valid}, 32'h0);
    check("skew_a1_busy", {31'b0, busy}, 32'h1);
    nxt();                                         // a+2: pop edge
    check("skew_row1_valid", {31'b0, a_valid}, 32'h1);
    check("skew_row1", a_vec, 32'h01000000);
    nxt();
    check("skew_row2", a_vec, 32'h00020000);
    check("skew_row2_valid", {31'b0, a_valid}, 32'h0);
    nxt();
    check("skew_row3", a_vec, 32'h00000300);
    nxt();
    check("skew_row4", a_vec, 32'h00000004);
    nxt();
    nxt();
    nxt();                                         // a+8
    check("skew_dd_early", {31'b0, drain_done}, 32'h0);
    check("skew_busy_drain", {31'b0, busy}, 32'h1);
    nxt();                                         // a+9 = pop + 7
    check("skew_dd_pulse", {31'b0, drain_done}, 32'h1);
    check("skew_busy_low", {31'b0, busy}, 32'h0);
    nxt();
    check("skew_dd_single", {31'b0, drain_done}, 32'h0);

    // Back-to-back packet of four
    drive(32'h11111111, 1'b0);
    nxt();                                         // a
    drive(32'h22222222, 1'b0);
    nxt();                                         // a+1
    check("b2b_v_a1", {31'b0, a_valid}, 32'h0);
    drive(32'h33333333, 1'b0);
    nxt();                                         // a+2
    check("b2b_v_a2", {31'b0, a_valid}, 32'h1);
    drive(32'h44444444, 1'b1);
    nxt();                                         // a+3
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("b2b_v_a3", {31'b0, a_valid}, 32'h1);
    nxt();
    check("b2b_v_a4", {31'b0, a_valid}, 32'h1);
    nxt();
    check("b2b_v_a5", {31'b0, a_valid}, 32'h1);
    check("b2b_diag", a_vec, 32'h44332211);
    nxt();
    check("b2b_v_a6", {31'b0, a_valid}, 32'h0);
    wait_drain();

    // Backpressure while a prior packet drains
    drive(32'hA0A0A0A0, 1'b1);
    nxt();                                         // a
    in_valid = 1'b0;
    nxt();
    nxt();                                         // a+2: popped, DRAIN
    check("bp_busy", {31'b0, busy}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      drive(32'hB0000000 + 32'(i), 1'b0);
      nxt();                                       // a+3 .. a+6
      check("bp_ready", {31'b0, in_ready}, (i < 3) ? 32'h1 : 32'h0);
    end
    drive(32'hB5B5B5B5, 1'b1);                     // held until space frees
    for (int i = 0; i < 3; i++) begin
      nxt();                                       // a+7 .. a+9
      check("bp_no_pop", {31'b0, a_valid}, 32'h0);
    end
    check("bp_dd", {31'b0, drain_done}, 32'h1);
    check("bp_full", {31'b0, in_ready}, 32'h0);
    nxt();                                         // a+10: IDLE -> STREAM
    check("bp_full_idle", {31'b0, in_ready}, 32'h0);
    check("bp_no_pop_idle", {31'b0, a_valid}, 32'h0);
    nxt();                                         // a+11: first pop
    check("bp_first_pop", {31'b0, a_valid}, 32'h1);
    check("bp_ready_rise", {31'b0, in_ready}, 32'h1);
    nxt();                                         // a+12: held vector taken
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_drain();

    // Bubble between A and B
    drive(32'hAAAAAAAA, 1'b0);
    nxt();                                         // a
    in_valid = 1'b0;
    nxt();
    nxt();                                         // a+2: pop A
    check("bub_a_valid", {31'b0, a_valid}, 32'h1);
    nxt();                                         // a+3
    check("bub_gap_valid", {31'b0, a_valid}, 32'h0);
    check("bub_gap_row1", {24'b0, a_vec[31:24]}, 32'h0);
    nxt();                                         // a+4
    check("bub_gap2_valid", {31'b0, a_valid}, 32'h0);
    drive(32'hBBBBBBBB, 1'b1);
    nxt();                                         // a+5: B accepted
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("bub_gap3_valid", {31'b0, a_valid}, 32'h0);
    nxt();                                         // a+6: pop B
    check("bub_b_valid", {31'b0, a_valid}, 32'h1);
`ifdef SA_WS_FEEDER_PERF_EN
    check("bub_cnt", {16'b0, bubble_cnt}, 32'd3);
`endif
    wait_drain();

    // Reset during STREAM with two entries buffered
    drive(32'hC1C1C1C1, 1'b0);
    nxt();
    drive(32'hC2C2C2C2, 1'b0);
    nxt();
    drive(32'hC3C3C3C3, 1'b0);
    nxt();                                         // C1 popped, C2/C3 buffered
    in_valid = 1'b0;
    check("mid_valid", {31'b0, a_valid}, 32'h1);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_a_vec", a_vec, 32'h0);
    check("mid_rst_a_valid", {31'b0, a_valid}, 32'h0);
    check("mid_rst_busy", {31'b0, busy}, 32'h0);
    check("mid_rst_dd", {31'b0, drain_done}, 32'h0);
    nxt();
    nxt();
    reset = 1'b1;
    #1;
    check("mid_rel_ready", {31'b0, in_ready}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      nxt();
      check("mid_no_stale", {31'b0, a_valid}, 32'h0);
      check("mid_idle", {31'b0, busy}, 32'h0);
    end

    // Normal operation after reset
    drive(32'hDEADBEEF, 1'b1);
    nxt();
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_drain();
    repeat (4) nxt();
    check("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
